// File: rtl/fpu_wb_queue.sv
// FPU writeback queue: in-order allocate, fill and retire of
// in-flight FP results towards the shared writeback stage.
module fpu_wb_queue #(
  parameter int DATA  = 32,
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH+1),
  parameter int RW    = 5,
  parameter int EW    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_,
  input  logic            issue_e_,
  input  logic [RW-1:0]   rd,
  input  logic            done_,
  input  logic            exp_,
  input  logic [EW-1:0]   exp_code,
  input  logic [DATA-1:0] fpu_res,
  input  logic            wb_ack_,
  output logic            wb_req_,
  output logic [RW-1:0]   pre_wb_rd,
  output logic            wb_e_,
  output logic [RW-1:0]   wb_rd,
  output logic [DATA-1:0] wb_data,
  output logic            wb_exp_,
  output logic [EW-1:0]   wb_exp_code,
  output logic [CNTW-1:0] count,
  output logic            busy
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    FREE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } ent_e;

  ent_e            st     [DEPTH];
  logic [RW-1:0]   rd_q   [DEPTH];
  logic [DATA-1:0] data_q [DEPTH];
  logic            exp_q  [DEPTH];
  logic [EW-1:0]   code_q [DEPTH];

  logic [PW-1:0] head;
  logic [PW-1:0] fill;
  logic [PW-1:0] tail;

  logic do_issue;
  logic do_done;
  logic do_ret;

  always_comb begin
    do_issue = !issue_e_ && (count != CNTW'(DEPTH));
    do_done  = !done_ && (st[fill] == WAIT);
    do_ret   = (st[head] == DONE) && !wb_ack_;
  end

  assign wb_req_   = (st[head] != DONE);
  assign pre_wb_rd = rd_q[head];
  assign busy      = (count == CNTW'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        st[i]     <= FREE;
        rd_q[i]   <= '0;
        data_q[i] <= '0;
        exp_q[i]  <= 1'b1;
        code_q[i] <= '0;
      end
      head        <= '0;
      fill        <= '0;
      tail        <= '0;
      count       <= '0;
      wb_e_       <= 1'b1;
      wb_rd       <= '0;
      wb_data     <= '0;
      wb_exp_     <= 1'b1;
      wb_exp_code <= '0;
    end else if (!flush_) begin
      for (int i = 0; i < DEPTH; i++) begin
        st[i] <= FREE;
      end
      head  <= '0;
      fill  <= '0;
      tail  <= '0;
      count <= '0;
      wb_e_ <= 1'b1;
    end else begin
      // Issue, fill and retire always touch distinct entries.
      if (do_issue) begin
        st[tail]   <= WAIT;
        rd_q[tail] <= rd;
        tail       <= tail + PW'(1);
      end
      if (do_done) begin
        st[fill]     <= DONE;
        data_q[fill] <= fpu_res;
        exp_q[fill]  <= exp_;
        code_q[fill] <= exp_code;
        fill         <= fill + PW'(1);
      end
      wb_e_ <= !do_ret;
      if (do_ret) begin
        st[head]    <= FREE;
        head        <= head + PW'(1);
        wb_rd       <= rd_q[head];
        wb_data     <= data_q[head];
        wb_exp_     <= exp_q[head];
        wb_exp_code <= code_q[head];
      end
      count <= count + CNTW'(do_issue) - CNTW'(do_ret);
    end
  end

endmodule

// File: tb/tb_fpu_wb_queue.sv
// Randomised + directed bench for fpu_wb_queue with a
// queue-based reference model and writeback scoreboard.
module tb_fpu_wb_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_;
  logic        issue_e_;
  logic [4:0]  rd;
  logic        done_;
  logic        exp_;
  logic [3:0]  exp_code;
  logic [31:0] fpu_res;
  logic        wb_ack_;
  logic        wb_req_;
  logic [4:0]  pre_wb_rd;
  logic        wb_e_;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exp_;
  logic [3:0]  wb_exp_code;
  logic [2:0]  count;
  logic        busy;

  fpu_wb_queue #(
    .DATA(32), .DEPTH(DEPTH), .RW(5), .EW(4)
  ) dut (
    .clk(clk), .reset(reset), .flush_(flush_),
    .issue_e_(issue_e_), .rd(rd), .done_(done_),
    .exp_(exp_), .exp_code(exp_code), .fpu_res(fpu_res),
    .wb_ack_(wb_ack_), .wb_req_(wb_req_),
    .pre_wb_rd(pre_wb_rd), .wb_e_(wb_e_), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_exp_(wb_exp_),
    .wb_exp_code(wb_exp_code), .count(count), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    bit          done;
    logic [31:0] data;
    logic        ex;
    logic [3:0]  code;
  } ent_t;

  ent_t mq[$];
  ent_t sbq[$];
  bit   rst_seen;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input bit ok,
                     input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a list of in-flight ops, oldest first.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      sbq.delete();
      rst_seen = 1'b1;
    end else if (!flush_) begin
      mq.delete();
      rst_seen = 1'b0;
    end else begin
      int k;
      bit ret;
      rst_seen = 1'b0;
      ret = (mq.size() > 0) && mq[0].done && !wb_ack_;
      k = -1;
      foreach (mq[i]) if (k < 0 && !mq[i].done) k = i;
      if (!done_ && k >= 0) begin
        mq[k].done = 1'b1;
        mq[k].data = fpu_res;
        mq[k].ex   = exp_;
        mq[k].code = exp_code;
      end
      if (ret) sbq.push_back(mq.pop_front());
      if (!issue_e_ && (mq.size() + (ret ? 1 : 0)) < DEPTH) begin
        ent_t e;
        e.rd = rd; e.done = 1'b0; e.data = '0;
        e.ex = 1'b1; e.code = '0;
        mq.push_back(e);
      end
    end
  end

  // Monitor: compare DUT outputs against model after each edge.
  always @(posedge clk) begin
    #1;
    if (!wb_e_) begin
      if (sbq.size() == 0) begin
        chk("wb_e_ spurious", 1'b0, 64'(wb_e_), 64'd1);
      end else begin
        ent_t e;
        e = sbq.pop_front();
        chk("wb_rd", wb_rd == e.rd, 64'(wb_rd), 64'(e.rd));
        chk("wb_data", wb_data == e.data, 64'(wb_data), 64'(e.data));
        chk("wb_exp_", wb_exp_ == e.ex, 64'(wb_exp_), 64'(e.ex));
        chk("wb_exp_code", wb_exp_code == e.code,
            64'(wb_exp_code), 64'(e.code));
      end
    end else if (sbq.size() > 0) begin
      chk("wb_e_ missing", 1'b0, 64'(wb_e_), 64'd0);
      void'(sbq.pop_front());
    end
    chk("count", count == 3'(mq.size()), 64'(count), 64'(mq.size()));
    chk("busy", busy == (mq.size() == DEPTH),
        64'(busy), 64'(mq.size() == DEPTH));
    begin
      bit req;
      req = (mq.size() > 0) && mq[0].done;
      chk("wb_req_", wb_req_ == !req, 64'(wb_req_), 64'(!req));
      if (req)
        chk("pre_wb_rd", pre_wb_rd == mq[0].rd,
            64'(pre_wb_rd), 64'(mq[0].rd));
    end
    if (rst_seen) begin
      chk("rst wb_rd", wb_rd == 0, 64'(wb_rd), 64'd0);
      chk("rst wb_data", wb_data == 0, 64'(wb_data), 64'd0);
      chk("rst wb_exp_", wb_exp_ == 1, 64'(wb_exp_), 64'd1);
      chk("rst wb_exp_code", wb_exp_code == 0, 64'(wb_exp_code), 64'd0);
      chk("rst pre_wb_rd", pre_wb_rd == 0, 64'(pre_wb_rd), 64'd0);
      chk("rst wb_e_", wb_e_ == 1, 64'(wb_e_), 64'd1);
    end
  end

  task automatic cyc(input logic i, input logic [4:0] r,
                     input logic d, input logic [31:0] res,
                     input logic e, input logic [3:0] c,
                     input logic a, input logic f);
    issue_e_ = i; rd = r; done_ = d; fpu_res = res;
    exp_ = e; exp_code = c; wb_ack_ = a; flush_ = f;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1, 0, 1, 0, 1, 0, 1, 1);
  endtask

  initial begin
    reset = 1'b1;
    issue_e_ = 1; rd = 0; done_ = 1; fpu_res = 0;
    exp_ = 1; exp_code = 0; wb_ack_ = 1; flush_ = 1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(2);
    // Single op, minimum latency.
    cyc(0, 5, 1, 0, 1, 0, 1, 1);
    cyc(1, 0, 0, 32'h3F80_0000, 1, 0, 1, 1);
    cyc(1, 0, 1, 0, 1, 0, 0, 1);
    idle(2);
    // Fill to full, drop a fifth issue, drain, repeat for wrap.
    for (int b = 0; b < 2; b++) begin
      for (int n = 0; n < 5; n++)
        cyc(0, 5'(10 + n + 8*b), 1, 0, 1, 0, 1, 1);
      for (int n = 0; n < 4; n++)
        cyc(1, 0, 0, 32'(n + 100*b), 1, 0, 0, 1);
      idle(2);
    end
    // Held ack with results waiting.
    cyc(0, 7, 1, 0, 1, 0, 1, 1);
    cyc(0, 8, 0, 32'hAAAA, 1, 0, 1, 1);
    cyc(1, 0, 0, 32'hBBBB, 1, 0, 1, 1);
    idle(1);
    cyc(1, 0, 1, 0, 1, 0, 0, 1);
    cyc(1, 0, 1, 0, 1, 0, 0, 1);
    idle(2);
    // Exception then clean result.
    cyc(0, 3, 1, 0, 1, 0, 1, 1);
    cyc(0, 4, 0, 32'h1, 0, 4'h2, 1, 1);
    cyc(1, 0, 0, 32'h2, 1, 0, 0, 1);
    cyc(1, 0, 1, 0, 1, 0, 0, 1);
    idle(2);
    // Flush with 1 DONE, 2 WAIT and a concurrent ack.
    cyc(0, 1, 1, 0, 1, 0, 1, 1);
    cyc(0, 2, 0, 32'h55, 1, 0, 1, 1);
    cyc(0, 6, 1, 0, 1, 0, 1, 1);
    cyc(1, 0, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 32'h66, 1, 0, 1, 1);
    idle(2);
    // Issue and retire together at count 2, then reset mid-burst.
    cyc(0, 9, 1, 0, 1, 0, 1, 1);
    cyc(0, 11, 0, 32'h77, 1, 0, 1, 1);
    cyc(0, 12, 1, 0, 1, 0, 0, 1);
    cyc(0, 13, 0, 32'h88, 1, 0, 0, 1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(2);
    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 499) == 0);
      cyc($urandom_range(0, 2) == 0, 5'($urandom),
          $urandom_range(0, 2) == 0, $urandom,
          $urandom_range(0, 4) != 0, 4'($urandom),
          $urandom_range(0, 2) == 0,
          $urandom_range(0, 99) != 0);
    end
    reset = 1'b0;
    repeat (12) cyc(1, 0, 0, 32'h9, 1, 0, 0, 1);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_wb_queue.md
# fpu_wb_queue

Parametrised FPU writeback controller holding up to DEPTH in-flight floating-point operations between issue and register-file writeback. Entries are allocated in program order at issue, filled in order as the pipelined FPU returns results, and retired in order through the shared writeback arbiter's request/acknowledge handshake. Sits between the FPU datapath and the common writeback stage. Unlike the single-slot controller, it supports multiple outstanding operations, exposes occupancy, and applies backpressure only when full.

## Interface
- DATA, `DataWidth: result width in bits
- DEPTH, 4: entry count, power of two, ≥2
- CNTW, $clog2(DEPTH+1): occupancy counter width
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush_  in  1  active-low pipeline flush
- issue_e_  in  1  active-low issue strobe, allocates one entry
- rd  in  RegFile_t  destination register of issued op
- done_  in  1  active-low FPU result strobe, fills oldest unfilled entry
- exp_  in  1  active-low exception flag accompanying result
- exp_code  in  ExpCode_t  exception code accompanying result
- fpu_res  in  DATA  FPU result
- wb_ack_  in  1  active-low writeback grant
- wb_req_  out  1  active-low writeback request
- pre_wb_rd  out  RegFile_t  destination of the head entry, valid while wb_req_ low
- wb_e_  out  1  active-low writeback enable
- wb_rd  out  RegFile_t  writeback destination
- wb_data  out  DATA  writeback data
- wb_exp_  out  1  active-low writeback exception
- wb_exp_code  out  ExpCode_t  writeback exception code
- count  out  CNTW  number of occupied entries
- busy  out  1  high when count == DEPTH

## Operation
- Circular buffer with three pointers: head (retire), fill (next entry awaiting a result), tail (allocate). Each pointer is log2(DEPTH) bits and wraps modulo DEPTH. Per-entry state: FREE, WAIT (allocated, no result), DONE (result captured).
- Issue: if issue_e_ is low and count < DEPTH at the start of the cycle, write rd to the tail, set the entry to WAIT and advance tail. Issue while full is dropped with no state change, even if a pop occurs in the same cycle. Upstream must honour busy.
- Result: if done_ is low and the entry at fill is WAIT, capture fpu_res, exp_ and exp_code, set the entry to DONE and advance fill. A done_ with no WAIT entry at cycle start is ignored, including when an issue happens in the same cycle.
- Request: wb_req_ = 0 iff the head entry is DONE. pre_wb_rd = head rd, combinational from registered state.
- Retire: when wb_req_ = 0 and wb_ack_ = 0, register the head rd, data, exp_ and exp_code into the wb_* outputs, drive wb_e_ low for exactly one cycle, free the head and advance it. wb_ack_ while wb_req_ is high is ignored.
- count: +1 on an accepted issue, −1 on a retire. Both in one cycle leave count unchanged. No overflow or underflow by construction.
- Flush (flush_ low): next cycle all entries are FREE, all pointers and count are 0, and wb_e_ is high. An issue, result or ack in the flush cycle is discarded. Flush has priority over everything except reset.
- Reset has priority over flush.

## Timing
- Reset values: wb_req_=1, pre_wb_rd=0, wb_e_=1, wb_rd=0, wb_data=0, wb_exp_=1, wb_exp_code=0, count=0, busy=0. All entries FREE with zeroed fields.
- Issue at cycle t: entry WAIT at t+1, and count and busy update at t+1.
- Result at cycle t into the head entry: wb_req_ low at t+1.
- Ack at cycle t: wb_e_ low at t+1 with the data valid. The next entry's request is visible at t+1 if it is DONE, giving one retirement per cycle sustained.
- Minimum issue-to-wb_e_: issue t0, done t1, ack t2, wb_e_ t3.
- No result bypass. Results never overtake in-order retirement.

## Test plan
- Reset then idle: all outputs at reset values. Issue rd=5 at t0, done_ with fpu_res=0x3F800000 at t1, ack at t2 -> wb_e_=0, wb_rd=5, wb_data=0x3F800000, wb_exp_=1 at t3 and count=0 at t4.
- DEPTH=4, issue 4 back-to-back -> busy=1 and count=4. A 5th issue is dropped. Retire all 4 with ack held low -> wb_rd is the issue order on 4 consecutive cycles, and pointers wrap correctly on a second burst of 4.
- Results arrive while ack is held high for 3 cycles -> wb_req_ stays low and pre_wb_rd is stable. Ack low at cycle 4 -> exactly one wb_e_ pulse per ack.
- Result with exp_=0, exp_code=illegal-op code -> wb_exp_=0 and wb_exp_code matches at writeback. The following entry without exception -> wb_exp_=1.
- Flush with 3 entries (1 DONE, 2 WAIT) and a concurrent ack -> no wb_e_ next cycle, count=0, and a later done_ is ignored.
- Simultaneous issue and retire at count=2 -> count stays 2. Synchronous reset asserted mid-burst -> all outputs at reset values the next cycle.
